mem_arbiter_ctrl: RTL

- Two-port arbiter and sequencer in front of the single-port main memory (9-bit address, 8-bit data, rd_mem/wr_mem/ready_mem handshake).
- Requester 0 is the instruction-fetch path and requester 1 the data path.
- Each request is one of two kinds: a 4-word line read, returned beat by beat, or a single-word write.
- Arbitration is round-robin. The block drives memory commands, paces them on ready_mem, and aborts on a stuck-busy timeout.

---
 rtl/mem_arbiter_ctrl_pkg.sv | 24 ++
 rtl/mem_arbiter_ctrl_if.sv | 40 ++++
 rtl/mem_arbiter_ctrl_arb.sv | 36 +++
 rtl/mem_arbiter_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mem_ctrl_pkg
// Shared definitions for the two-port memory arbiter/sequencer:
//   state_t       - sequencer states
//   LINE_WORDS    - words per cache line returned by a line read
//   OFFSET_BITS   - address bits selecting a word inside a line
//   TCNT_W        - width of the ready_mem stuck-busy timeout counter
// ---------------------------------------------------------------------------
package mem_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_CMD  = 3'd1,
        RD_CAP  = 3'd2,
        RD_WAIT = 3'd3,
        WR_CMD  = 3'd4,
        WR_WAIT = 3'd5
    } state_t;

    localparam int LINE_WORDS  = 4;
    localparam int OFFSET_BITS = 2;
    localparam int TCNT_W      = 8;

endpackage

// File: rtl/mem_arbiter_ctrl_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_ctrl_if
// One requester's request/response channel into mem_arbiter_ctrl.
//   valid/we/addr/wdata : request, held stable by the requester until ready
//   ready               : one-cycle accept pulse from the arbiter
//   rsp_valid/rsp_data  : read beat (or write acknowledge / abort)
//   rsp_beat            : word index of the beat within the line
//   rsp_last            : final beat of a read, or the write acknowledge
//   rsp_err             : stuck-busy timeout abort
// master = requester side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface mem_arbiter_ctrl_if
    import mem_ctrl_pkg::*;
#(
    parameter int AWIDTH = 9,
    parameter int DWIDTH = 8
);

    logic                   valid;
    logic                   we;
    logic [AWIDTH-1:0]      addr;
    logic [DWIDTH-1:0]      wdata;
    logic                   ready;
    logic                   rsp_valid;
    logic [DWIDTH-1:0]      rsp_data;
    logic [OFFSET_BITS-1:0] rsp_beat;
    logic                   rsp_last;
    logic                   rsp_err;

    modport master (
        output valid, we, addr, wdata,
        input  ready, rsp_valid, rsp_data, rsp_beat, rsp_last, rsp_err
    );

    modport slave (
        input  valid, we, addr, wdata,
        output ready, rsp_valid, rsp_data, rsp_beat, rsp_last, rsp_err
    );

endinterface

// File: rtl/mem_arbiter_ctrl_arb.sv
// ---------------------------------------------------------------------------
// rr_arbiter2
// Two-way round-robin arbiter. Grants are combinational from the request
// lines and the remembered last winner; the winner is registered whenever a
// grant is issued so that the other requester wins the next tie.
//   clk, reset     : clock, asynchronous active-high reset
//   enable         : arbitration allowed this cycle
//   req0, req1     : requests
//   grant0, grant1 : one-hot (or zero) grant
// After reset last_grant=1, so requester 0 wins the first tie.
// ---------------------------------------------------------------------------
module rr_arbiter2 (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic req0,
    input  logic req1,
    output logic grant0,
    output logic grant1
);

    logic last_grant;

    // On a tie the requester that did not win last time is served.
    assign grant0 = enable & req0 & (~req1 | last_grant);
    assign grant1 = enable & req1 & (~req0 | ~last_grant);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= 1'b1;
        end else if (grant0 | grant1) begin
            last_grant <= grant1;
        end
    end

endmodule

// File: rtl/mem_arbiter_ctrl.sv
// ---------------------------------------------------------------------------
// mem_arbiter_ctrl
// Round-robin arbiter and command sequencer placing two requesters
// (0 = instruction fetch, 1 = data) in front of a single-port memory.
// A request is either a 4-word line read, returned beat by beat, or a
// single-word write. Memory commands are paced on ready_mem, and a
// transaction is aborted if ready_mem stays low for TIMEOUT cycles.
//
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   req0, req1      : requester channels (mem_arbiter_ctrl_if.slave)
//   rd_mem, wr_mem  : one-cycle memory read / write commands
//   addr_mem        : memory address
//   data_to_mem     : memory write data
//   data_from_mem   : memory read data, valid one cycle after rd_mem
//   ready_mem       : memory idle (1) / busy (0)
// All outputs are registered.
// ---------------------------------------------------------------------------
module mem_arbiter_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int AWIDTH  = 9,
    parameter int DWIDTH  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                reset,
    mem_arbiter_ctrl_if.slave   req0,
    mem_arbiter_ctrl_if.slave   req1,
    output logic                rd_mem,
    output logic                wr_mem,
    output logic [AWIDTH-1:0]   addr_mem,
    output logic [DWIDTH-1:0]   data_to_mem,
    input  logic [DWIDTH-1:0]   data_from_mem,
    input  logic                ready_mem
);

    // Word address of a given beat inside the line containing a.
    function automatic logic [AWIDTH-1:0] beat_addr(
        input logic [AWIDTH-1:0]      a,
        input logic [OFFSET_BITS-1:0] b
    );
        return {a[AWIDTH-1:OFFSET_BITS], b};
    endfunction

    // Registered state
    state_t                 state;
    logic [OFFSET_BITS-1:0] beat;
    logic                   owner;
    logic [AWIDTH-1:0]      lat_addr;
    logic [TCNT_W-1:0]      tcnt;

    // Next-state values
    state_t                 state_n;
    logic [OFFSET_BITS-1:0] beat_n;
    logic                   owner_n;
    logic [AWIDTH-1:0]      lat_addr_n;
    logic [TCNT_W-1:0]      tcnt_n;

    // Next output values
    logic                   rd_n;
    logic                   wr_n;
    logic [AWIDTH-1:0]      maddr_n;
    logic [DWIDTH-1:0]      mdata_n;
    logic [1:0]             ready_n;
    logic                   rsp_valid_n;
    logic [DWIDTH-1:0]      rsp_data_n;
    logic [OFFSET_BITS-1:0] rsp_beat_n;
    logic                   rsp_last_n;
    logic                   rsp_err_n;

    // Arbitration
    logic                   arb_en;
    logic                   gnt0;
    logic                   gnt1;
    logic                   pick_we;
    logic [AWIDTH-1:0]      pick_addr;
    logic [DWIDTH-1:0]      pick_wdata;
    logic                   timed_out;

    // A new transaction may only start when the memory is idle.
    assign arb_en = (state == IDLE) && ready_mem;

    rr_arbiter2 u_arb (
        .clk    (clk),
        .reset  (reset),
        .enable (arb_en),
        .req0   (req0.valid),
        .req1   (req1.valid),
        .grant0 (gnt0),
        .grant1 (gnt1)
    );

    assign pick_we    = gnt1 ? req1.we    : req0.we;
    assign pick_addr  = gnt1 ? req1.addr  : req0.addr;
    assign pick_wdata = gnt1 ? req1.wdata : req0.wdata;

    // The counter is cleared on wait-state entry and bumped per busy cycle;
    // when this compare hits, the current busy cycle is the TIMEOUT-th one.
    assign timed_out = (tcnt == TCNT_W'(TIMEOUT - 1));

    always_comb begin
        state_n     = state;
        beat_n      = beat;
        owner_n     = owner;
        lat_addr_n  = lat_addr;
        tcnt_n      = tcnt;
        rd_n        = 1'b0;
        wr_n        = 1'b0;
        maddr_n     = '0;
        mdata_n     = '0;
        ready_n     = 2'b00;
        rsp_valid_n = 1'b0;
        rsp_data_n  = '0;
        rsp_beat_n  = '0;
        rsp_last_n  = 1'b0;
        rsp_err_n   = 1'b0;

        case (state)
            IDLE: begin
                if (gnt0 | gnt1) begin
                    owner_n    = gnt1;
                    lat_addr_n = pick_addr;
                    ready_n    = {gnt1, gnt0};
                    // Outputs are registered, so the command for the first
                    // cycle of the next state is launched from here.
                    if (pick_we) begin
                        state_n = WR_CMD;
                        wr_n    = 1'b1;
                        maddr_n = pick_addr;
                        mdata_n = pick_wdata;
                    end else begin
                        state_n = RD_CMD;
                        beat_n  = '0;
                        rd_n    = 1'b1;
                        maddr_n = beat_addr(pick_addr, '0);
                    end
                end
            end

            RD_CMD: begin
                state_n = RD_CAP;
            end

            RD_CAP: begin
                rsp_valid_n = 1'b1;
                rsp_data_n  = data_from_mem;
                rsp_beat_n  = beat;
                rsp_last_n  = (beat == OFFSET_BITS'(LINE_WORDS - 1));
                beat_n      = beat + 1'b1;
                tcnt_n      = '0;
                state_n     = RD_WAIT;
            end

            RD_WAIT: begin
                if (ready_mem) begin
                    // beat has already advanced; zero means the line wrapped.
                    if (beat == '0) begin
                        state_n = IDLE;
                    end else begin
                        state_n = RD_CMD;
                        rd_n    = 1'b1;
                        maddr_n = beat_addr(lat_addr, beat);
                    end
                end else if (timed_out) begin
                    rsp_valid_n = 1'b1;
                    rsp_last_n  = 1'b1;
                    rsp_err_n   = 1'b1;
                    beat_n      = '0;
                    state_n     = IDLE;
                end else begin
                    tcnt_n = tcnt + 1'b1;
                end
            end

            WR_CMD: begin
                tcnt_n  = '0;
                state_n = WR_WAIT;
            end

            WR_WAIT: begin
                if (ready_mem) begin
                    rsp_valid_n = 1'b1;
                    rsp_last_n  = 1'b1;
                    state_n     = IDLE;
                end else if (timed_out) begin
                    rsp_valid_n = 1'b1;
                    rsp_last_n  = 1'b1;
                    rsp_err_n   = 1'b1;
                    beat_n      = '0;
                    state_n     = IDLE;
                end else begin
                    tcnt_n = tcnt + 1'b1;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            beat            <= '0;
            owner           <= 1'b0;
            lat_addr        <= '0;
            tcnt            <= '0;
            rd_mem          <= 1'b0;
            wr_mem          <= 1'b0;
            addr_mem        <= '0;
            data_to_mem     <= '0;
            req0.ready      <= 1'b0;
            req0.rsp_valid  <= 1'b0;
            req0.rsp_data   <= '0;
            req0.rsp_beat   <= '0;
            req0.rsp_last   <= 1'b0;
            req0.rsp_err    <= 1'b0;
            req1.ready      <= 1'b0;
            req1.rsp_valid  <= 1'b0;
            req1.rsp_data   <= '0;
            req1.rsp_beat   <= '0;
            req1.rsp_last   <= 1'b0;
            req1.rsp_err    <= 1'b0;
        end else begin
            state           <= state_n;
            beat            <= beat_n;
            owner           <= owner_n;
            lat_addr        <= lat_addr_n;
            tcnt            <= tcnt_n;
            rd_mem          <= rd_n;
            wr_mem          <= wr_n;
            addr_mem        <= maddr_n;
            data_to_mem     <= mdata_n;
            req0.ready      <= ready_n[0];
            req1.ready      <= ready_n[1];
            // Only the owning port's response channel ever moves.
            req0.rsp_valid  <= rsp_valid_n & ~owner;
            req0.rsp_data   <= owner ? '0 : rsp_data_n;
            req0.rsp_beat   <= owner ? '0 : rsp_beat_n;
            req0.rsp_last   <= rsp_last_n & ~owner;
            req0.rsp_err    <= rsp_err_n & ~owner;
            req1.rsp_valid  <= rsp_valid_n & owner;
            req1.rsp_data   <= owner ? rsp_data_n : '0;
            req1.rsp_beat   <= owner ? rsp_beat_n : '0;
            req1.rsp_last   <= rsp_last_n & owner;
            req1.rsp_err    <= rsp_err_n & owner;
        end
    end

endmodule
